// File: rtl/pio_strobe_fir_pkg.sv
// pio_strobe_fir_pkg: shared states, default sizes and accumulator width for the strobed FIR
package pio_strobe_fir_pkg;
  localparam int TAPS_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, MAC = ST_MAC, DONE = ST_DONE} state_t;
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus registered rising-edge pulse, blind to a level already high at reset release
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);
  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, armed_q, armed_d, pulse_q, pulse_d;
  logic [1:0] fill_q, fill_d;
  // armed only after a genuinely synchronized low is seen, so a high pin at release is not an edge
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    prev_d = s2_q;
    fill_d = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);
    pulse_d = s2_q & ~prev_q & armed_q;
  end
  // synchronizer, edge history and pulse registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1_q, s2_q, prev_q, armed_q, pulse_q, fill_q} <= '0;
    else {s1_q, s2_q, prev_q, armed_q, pulse_q, fill_q} <= {s1_d, s2_d, prev_d, armed_d, pulse_d, fill_d};
  assign rise_pulse = pulse_q;
endmodule

// File: rtl/pio_strobe_fir.sv
// pio_strobe_fir: single-multiplier FIR clocked by a software-toggled sample strobe
module pio_strobe_fir
  import pio_strobe_fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_clk,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     overrun_clr,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int IW = $clog2(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  logic strobe, last, in_range;
  state_t state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_sh;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [DATA_W-1:0] result_q, result_d, sat_val;
  logic [IW-1:0] idx_q, idx_d;
  logic overrun_q, overrun_d;
  sync_edge_det u_sync (.clk(clk), .reset_n(reset_n), .async_in(sample_clk), .rise_pulse(strobe));
  // shared multiplier, accumulate, then Q1 rescale and saturate to the sample range
  always_comb begin
    prod = x_q[idx_q] * c_q[idx_q];
    acc_sum = acc_q + ACC_W'(prod);
    acc_sh = acc_sum >>> (COEF_W - 1);
    in_range = (&acc_sh[ACC_W-1:DATA_W-1]) | ~(|acc_sh[ACC_W-1:DATA_W-1]);
    sat_val = in_range ? acc_sh[DATA_W-1:0] : {acc_sh[ACC_W-1], {(DATA_W-1){~acc_sh[ACC_W-1]}}};
    last = idx_q == IW'(TAPS - 1);
  end
  // IDLE accepts samples and coefficient writes; MAC walks the taps; DONE publishes one result
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    c_d = c_q;
    acc_d = acc_q;
    idx_d = idx_q;
    result_d = result_q;
    overrun_d = overrun_clr ? 1'b0 : overrun_q;
    if (state_q == IDLE) begin
      if (coef_we) c_d[coef_addr] = coef_wdata;
      if (strobe) begin
        x_d[0] = sample_in;
        for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
        acc_d = '0;
        idx_d = '0;
        state_d = MAC;
      end
    end else begin
      if (strobe) overrun_d = 1'b1;
      if (state_q == MAC) begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (last) begin
          result_d = sat_val;
          state_d = DONE;
        end
      end else state_d = IDLE;
    end
  end
  // datapath and control registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      x_q <= '{default: '0};
      c_q <= '{default: '0};
      acc_q <= '0;
      idx_q <= '0;
      result_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      c_q <= c_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      result_q <= result_d;
      overrun_q <= overrun_d;
    end
  assign result = result_q;
  assign result_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_pio_strobe_fir.sv
// tb_pio_strobe_fir: scoreboard bench for the strobed FIR
module tb_pio_strobe_fir;
  localparam int TAPS = 8;
  logic clk = 0, reset_n = 0, sample_clk = 0, coef_we = 0, overrun_clr = 0;
  logic [15:0] sample_in = 0, coef_wdata = 0;
  logic [2:0] coef_addr = 0;
  logic [15:0] result;
  logic result_valid, busy, overrun;
  int errors = 0, checks = 0, valid_cnt = 0, exp_valid = 0, v0;
  logic [15:0] exp_q [$];
  longint xm [TAPS];
  longint cm [TAPS];
  pio_strobe_fir dut (
    .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .overrun_clr(overrun_clr),
    .result(result), .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] model();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += xm[k] * cm[k];
    s = s >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction
  task automatic push_sample(input logic [15:0] v);
    for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = longint'($signed(v));
    exp_q.push_back(model());
    exp_valid++;
  endtask
  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) begin
      xm[k] = 0;
      cm[k] = 0;
    end
  endtask
  task automatic wr_coef(input int a, input logic [15:0] v, input bit upd);
    coef_addr = 3'(a);
    coef_wdata = v;
    coef_we = 1;
    tick(1);
    coef_we = 0;
    if (upd) cm[a] = longint'($signed(v));
  endtask
  task automatic send(input logic [15:0] v);
    int n = 0;
    push_sample(v);
    sample_in = v;
    sample_clk = 1;
    while (n < 40 && !result_valid) begin
      tick(1);
      n++;
      if (n == 3) sample_clk = 0;
    end
    chk("latency", 64'(n), 64'(TAPS + 4));
    tick(2);
  endtask
  always @(negedge clk)
    if (result_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) chk("spurious_valid", 64'(result_valid), 64'(0));
      else chk("result", 64'(result), 64'(exp_q.pop_front()));
    end
  initial begin
    clear_model();
    tick(3);
    chk("rst_result", 64'(result), 0);
    chk("rst_valid", 64'(result_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_overrun", 64'(overrun), 0);
    reset_n = 1;
    tick(2);
    send(16'h1234);
    wr_coef(0, 16'h4000, 1);
    send(16'h1000);
    chk("half_gain", 64'(result), 64'h0800);
    push_sample(16'h0400);
    sample_in = 16'h0400;
    sample_clk = 1;
    tick(3);
    sample_clk = 0;
    tick(3);
    chk("busy_in_mac", 64'(busy), 1);
    wr_coef(0, 16'h7FFF, 0);
    tick(TAPS + 6);
    send(16'h2000);
    chk("coef_locked_busy", 64'(result), 64'h1000);
    for (int k = 0; k < TAPS; k++) wr_coef(k, 16'(16'h0100 * (k + 1)), 1);
    for (int i = 0; i < TAPS; i++) send(16'h0000);
    send(16'h7FFF);
    chk("impulse_0", 64'(result), 64'h00FF);
    for (int n = 1; n <= TAPS + 1; n++) begin
      send(16'h0000);
      chk($sformatf("impulse_%0d", n), 64'(result), n < TAPS ? 64'((32767 * 256 * (n + 1)) >>> 15) : 64'(0));
    end
    for (int k = 0; k < TAPS; k++) wr_coef(k, 16'h7FFF, 1);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF);
    chk("sat_pos", 64'(result), 64'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h8000);
    chk("sat_neg", 64'(result), 64'h8000);
    chk("no_overrun_yet", 64'(overrun), 0);
    sample_in = 16'h0123;
    sample_clk = 1;
    tick(3);
    coef_we = 1;
    coef_addr = 0;
    coef_wdata = 16'h2000;
    cm[0] = 64'h2000;
    push_sample(16'h0123);
    tick(1);
    coef_we = 0;
    sample_clk = 0;
    tick(TAPS + 6);
    v0 = valid_cnt;
    push_sample(16'h0200);
    sample_in = 16'h0200;
    sample_clk = 1;
    tick(2);
    sample_clk = 0;
    tick(2);
    sample_in = 16'h7777;
    sample_clk = 1;
    tick(3);
    sample_clk = 0;
    tick(TAPS + 6);
    chk("overrun_set", 64'(overrun), 1);
    chk("one_valid", 64'(valid_cnt - v0), 1);
    overrun_clr = 1;
    tick(1);
    overrun_clr = 0;
    chk("overrun_clr", 64'(overrun), 0);
    push_sample(16'h0300);
    sample_in = 16'h0300;
    sample_clk = 1;
    tick(2);
    sample_clk = 0;
    tick(2);
    sample_clk = 1;
    tick(3);
    overrun_clr = 1;
    tick(1);
    overrun_clr = 0;
    sample_clk = 0;
    chk("set_wins", 64'(overrun), 1);
    tick(TAPS + 6);
    v0 = valid_cnt;
    sample_in = 16'h0555;
    sample_clk = 1;
    tick(6);
    reset_n = 0;
    sample_clk = 0;
    #1;
    chk("abort_result", 64'(result), 0);
    chk("abort_valid", 64'(result_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_overrun", 64'(overrun), 0);
    clear_model();
    tick(2);
    reset_n = 1;
    tick(TAPS + 10);
    chk("abort_no_valid", 64'(valid_cnt - v0), 0);
    reset_n = 0;
    sample_clk = 1;
    tick(2);
    reset_n = 1;
    tick(20);
    chk("high_at_release_busy", 64'(busy), 0);
    chk("high_at_release_valid", 64'(valid_cnt - v0), 0);
    sample_clk = 0;
    tick(4);
    for (int k = 0; k < TAPS; k++) wr_coef(k, 16'($urandom), 1);
    for (int i = 0; i < 6; i++) send(16'($urandom));
    tick(4);
    chk("queue_empty", 64'(exp_q.size()), 0);
    chk("valid_count", 64'(valid_cnt), 64'(exp_valid));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
